// File: rtl/l1_port_arbiter.sv
// Shares the L1 D-cache request port between IF and LS: LS priority with an IF starvation guard.
// Latency: grant to cache access next cycle; response pulse one cycle after the cache completes.
// Backpressure: one outstanding access; ready only in IDLE to the winner; c_stall holds the access.
module l1_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  input  logic                  if_flush,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  ls_req_valid,
  input  logic                  ls_req_we,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_req_ready,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rsp_data,
  output logic                  c_cs,
  output logic                  c_we,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_wdata,
  input  logic                  c_stall,
  input  logic [DATA_WIDTH-1:0] c_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic       owner_if;
  logic [3:0] starve_cnt;
  logic       flush_pend;
  logic       if_rsp_q;
  logic       ls_rsp_q;
  logic       ls_win;
  logic       if_win;

  // Winner selection: LS first, unless IF has waited through LIMIT consecutive LS grants.
  always_comb begin
    ls_win = ls_req_valid & ~(if_req_valid & (starve_cnt == LIMIT));
    if_win = if_req_valid & ~ls_win;
  end

  // Ready only while idle; held low during reset so nothing is accepted.
  assign if_req_ready = ~rst & (state == IDLE) & if_win;
  assign ls_req_ready = ~rst & (state == IDLE) & ls_win;

  // A flush in the pulse cycle still kills a pending IF response.
  assign if_rsp_valid = if_rsp_q & ~if_flush;
  assign ls_rsp_valid = ls_rsp_q;

  // Arbitration FSM: latches the winner's request, holds it through stalls, captures read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_if    <= 1'b0;
      starve_cnt  <= '0;
      flush_pend  <= 1'b0;
      if_rsp_q    <= 1'b0;
      ls_rsp_q    <= 1'b0;
      if_rsp_data <= '0;
      ls_rsp_data <= '0;
      c_cs        <= 1'b0;
      c_we        <= 1'b0;
      c_addr      <= '0;
      c_wdata     <= '0;
    end else begin
      if_rsp_q <= 1'b0;
      ls_rsp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win | ls_win) begin
            state      <= ACCESS;
            c_cs       <= 1'b1;
            owner_if   <= if_win;
            flush_pend <= 1'b0;
            c_we       <= ls_win & ls_req_we;
            c_addr     <= ls_win ? ls_req_addr : if_req_addr;
            c_wdata    <= ls_win ? ls_req_wdata : '0;
            if (ls_win && if_req_valid)
              starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
            else
              starve_cnt <= '0;
          end
        end
        ACCESS: begin
          if (owner_if && if_flush)
            flush_pend <= 1'b1;
          if (!c_stall) begin
            state      <= IDLE;
            c_cs       <= 1'b0;
            flush_pend <= 1'b0;
            if (owner_if) begin
              if_rsp_data <= c_rdata;
              if_rsp_q    <= ~(flush_pend | if_flush);
            end else begin
              ls_rsp_data <= c_rdata;
              ls_rsp_q    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
